// File: rtl/code_loader_if.sv
// ----------------------------------------------------------------------------
// code_loader_if
//
// Purpose:
//   Bundles the byte-stream handshake and the code-segment write port used by
//   code_loader. The clock and reset stay outside the bundle as plain ports.
//
// Signals:
//   RX_DATA          8   incoming program byte
//   RX_VALID         1   RX_DATA valid this cycle
//   RX_READY         1   loader accepts a byte this cycle
//   CODE_WR_ADDRESS  8   code segment write address
//   CODE_WR_DATA     16  instruction word to write
//   CODE_WREN        1   write strobe, one cycle per word
//
// Modports:
//   master  byte producer / code memory side (drives RX_DATA, RX_VALID)
//   slave   loader side (drives RX_READY and the write port)
// ----------------------------------------------------------------------------
interface code_loader_if;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic [7:0]  CODE_WR_ADDRESS;
  logic [15:0] CODE_WR_DATA;
  logic        CODE_WREN;

  modport master (
    output RX_DATA,
    output RX_VALID,
    input  RX_READY,
    input  CODE_WR_ADDRESS,
    input  CODE_WR_DATA,
    input  CODE_WREN
  );

  modport slave (
    input  RX_DATA,
    input  RX_VALID,
    output RX_READY,
    output CODE_WR_ADDRESS,
    output CODE_WR_DATA,
    output CODE_WREN
  );
endinterface

// File: rtl/code_loader.sv
// ----------------------------------------------------------------------------
// code_loader
//
// Purpose:
//   Upstream stage of the processor. Receives a program as a byte stream
//   (count byte N, then N words high byte first; N=0 means 256 words),
//   writes each assembled 16-bit word into the code segment at addresses
//   0..N-1, then drives START low for START_PULSE_CYCLES cycles so the
//   processor restarts from IP=0. Everything runs on proc_clock.
//
// Parameters:
//   START_PULSE_CYCLES  cycles START is held low after a good load (1..255)
//   TIMEOUT_CYCLES      idle cycles allowed between bytes inside a frame
//                       before the frame is aborted; 0 disables the timeout
//
// Ports:
//   proc_clock  in   system clock, posedge
//   RESET       in   synchronous active-high reset
//   ld          if   code_loader_if.slave: byte handshake + code write port
//   START       out  processor start/reset, active low
//   BUSY        out  frame in progress (state other than IDLE)
//   DONE        out  sticky: last frame loaded and START pulsed
//   ERROR       out  sticky: last frame aborted
//
// Optional feature (macro CODE_LOADER_CHECKSUM_EN):
//   When defined, one extra byte follows the last word. It must equal the
//   XOR of the count byte and every payload byte; a mismatch aborts the
//   frame with ERROR instead of pulsing START. When undefined, the last
//   word write goes straight to the START pulse.
//
// All outputs come straight from flops; their next values are derived from
// the next state so that they line up with the state register.
// ----------------------------------------------------------------------------
module code_loader #(
  parameter int unsigned START_PULSE_CYCLES = 32'd4,
  parameter int unsigned TIMEOUT_CYCLES     = 32'd1000
) (
  input  logic            proc_clock,
  input  logic            RESET,
  code_loader_if.slave    ld,
  output logic            START,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERROR
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
`ifdef CODE_LOADER_CHECKSUM_EN
    ST_PULSE = 3'd4,
    ST_CHECK = 3'd5
`else
    ST_PULSE = 3'd4
`endif
  } state_t;

  // Last value of the pulse counter while START is low.
  localparam logic [7:0] PULSE_LAST = 8'(START_PULSE_CYCLES - 32'd1);

`ifdef CODE_LOADER_CHECKSUM_EN
  // Running frame checksum: XOR of the count byte and all payload bytes.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc,
                                           input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // Registered state
  state_t      state_r;
  logic [8:0]  words_left_r;
  logic [7:0]  addr_r;
  logic [15:0] data_r;
  logic [31:0] tmo_cnt_r;
  logic [7:0]  pulse_cnt_r;
  logic        ready_r;
  logic        wren_r;
  logic        start_r;
  logic        busy_r;
  logic        done_r;
  logic        error_r;
`ifdef CODE_LOADER_CHECKSUM_EN
  logic [7:0]  csum_r;
  logic [7:0]  csum_s;
`endif

  // Next-state values
  state_t      state_s;
  logic [8:0]  words_left_s;
  logic [7:0]  addr_s;
  logic [15:0] data_s;
  logic [31:0] tmo_cnt_s;
  logic [7:0]  pulse_cnt_s;
  logic        ready_s;
  logic        wren_s;
  logic        start_s;
  logic        busy_s;
  logic        done_s;
  logic        error_s;

  logic        accept_s;
  logic        tmo_hit_s;

  // A byte transfers only when the registered ready and the producer's valid
  // coincide; ready_r always mirrors whether state_r is an accepting state.
  assign accept_s  = ld.RX_VALID & ready_r;
  // Fires on the cycle that would be the TIMEOUT_CYCLES-th idle cycle.
  assign tmo_hit_s = (TIMEOUT_CYCLES != 32'd0) &&
                     (tmo_cnt_r == (TIMEOUT_CYCLES - 32'd1));

  // Next-state and next-output logic for the load FSM.
  always_comb begin
    state_s      = state_r;
    words_left_s = words_left_r;
    addr_s       = addr_r;
    data_s       = data_r;
    tmo_cnt_s    = tmo_cnt_r;
    pulse_cnt_s  = pulse_cnt_r;
    done_s       = done_r;
    error_s      = error_r;
`ifdef CODE_LOADER_CHECKSUM_EN
    csum_s       = csum_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          // A count of zero encodes a full 256-word segment.
          words_left_s = (ld.RX_DATA == 8'd0) ? 9'd256 : {1'b0, ld.RX_DATA};
          addr_s       = 8'd0;
          done_s       = 1'b0;
          error_s      = 1'b0;
          tmo_cnt_s    = 32'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
          csum_s       = ld.RX_DATA;
`endif
          state_s      = ST_HI;
        end else begin
          state_s      = ST_IDLE;
        end
      end

      ST_HI: begin
        if (accept_s) begin
          data_s    = {ld.RX_DATA, data_r[7:0]};
          tmo_cnt_s = 32'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
          csum_s    = csum_fold(csum_r, ld.RX_DATA);
`endif
          state_s   = ST_LO;
        end else if (tmo_hit_s) begin
          error_s   = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          tmo_cnt_s = tmo_cnt_r + 32'd1;
        end
      end

      ST_LO: begin
        if (accept_s) begin
          data_s    = {data_r[15:8], ld.RX_DATA};
          tmo_cnt_s = 32'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
          csum_s    = csum_fold(csum_r, ld.RX_DATA);
`endif
          state_s   = ST_WRITE;
        end else if (tmo_hit_s) begin
          error_s   = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          tmo_cnt_s = tmo_cnt_r + 32'd1;
        end
      end

      ST_WRITE: begin
        if (words_left_r == 9'd1) begin
          pulse_cnt_s  = 8'd0;
          tmo_cnt_s    = 32'd0;
`ifdef CODE_LOADER_CHECKSUM_EN
          state_s      = ST_CHECK;
`else
          state_s      = ST_PULSE;
`endif
        end else begin
          // Address wraps naturally; words_left guarantees no overrun.
          words_left_s = words_left_r - 9'd1;
          addr_s       = addr_r + 8'd1;
          tmo_cnt_s    = 32'd0;
          state_s      = ST_HI;
        end
      end

`ifdef CODE_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept_s) begin
          tmo_cnt_s = 32'd0;
          if (ld.RX_DATA == csum_r) begin
            pulse_cnt_s = 8'd0;
            state_s     = ST_PULSE;
          end else begin
            error_s     = 1'b1;
            state_s     = ST_IDLE;
          end
        end else if (tmo_hit_s) begin
          error_s   = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          tmo_cnt_s = tmo_cnt_r + 32'd1;
        end
      end
`endif

      ST_PULSE: begin
        if (pulse_cnt_r == PULSE_LAST) begin
          pulse_cnt_s = 8'd0;
          done_s      = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          pulse_cnt_s = pulse_cnt_r + 8'd1;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so the flops match state_r.
`ifdef CODE_LOADER_CHECKSUM_EN
    ready_s = (state_s == ST_IDLE) || (state_s == ST_HI) ||
              (state_s == ST_LO)   || (state_s == ST_CHECK);
`else
    ready_s = (state_s == ST_IDLE) || (state_s == ST_HI) ||
              (state_s == ST_LO);
`endif
    wren_s  = (state_s == ST_WRITE);
    start_s = (state_s != ST_PULSE);
    busy_s  = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge proc_clock) begin
    if (RESET) begin
      state_r      <= ST_IDLE;
      words_left_r <= 9'd0;
      addr_r       <= 8'd0;
      data_r       <= 16'd0;
      tmo_cnt_r    <= 32'd0;
      pulse_cnt_r  <= 8'd0;
      ready_r      <= 1'b0;
      wren_r       <= 1'b0;
      start_r      <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
      csum_r       <= 8'd0;
`endif
    end else begin
      state_r      <= state_s;
      words_left_r <= words_left_s;
      addr_r       <= addr_s;
      data_r       <= data_s;
      tmo_cnt_r    <= tmo_cnt_s;
      pulse_cnt_r  <= pulse_cnt_s;
      ready_r      <= ready_s;
      wren_r       <= wren_s;
      start_r      <= start_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      error_r      <= error_s;
`ifdef CODE_LOADER_CHECKSUM_EN
      csum_r       <= csum_s;
`endif
    end
  end

  assign ld.RX_READY        = ready_r;
  assign ld.CODE_WR_ADDRESS = addr_r;
  assign ld.CODE_WR_DATA    = data_r;
  assign ld.CODE_WREN       = wren_r;
  assign START              = start_r;
  assign BUSY               = busy_r;
  assign DONE               = done_r;
  assign ERROR              = error_r;

endmodule
